axi_rd_arbiter: RTL

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arb_pkg.sv | 66 ++++++
 rtl/axi_rd_arb_grant.sv | 73 +++++++
 rtl/axi_rd_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_arb_pkg
// Shared definitions for the two-master AXI read arbiter.
//
// Widths come from the AXI_define.svh macros (AXI_ADDR_BITS, AXI_LEN_BITS,
// AXI_SIZE_BITS, AXI_ID_BITS, AXI_IDS_BITS, AXI_DATA_BITS). When the build does
// not supply them, the guarded defaults below are used.
//
// Contents:
//   ADDR_W/LEN_W/SIZE_W/ID_W/IDS_W/DATA_W : channel widths
//   CNT_W    : beat counter width (holds ARLEN+1)
//   state_e  : arbiter FSM states (idle / address / data)
//   M0, M1   : master index constants
//   make_ids : builds the slave-side ARID {zeros, master index, master ARID}
// -----------------------------------------------------------------------------
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

package axi_rd_arb_pkg;

    localparam int unsigned ADDR_W = `AXI_ADDR_BITS;
    localparam int unsigned LEN_W  = `AXI_LEN_BITS;
    localparam int unsigned SIZE_W = `AXI_SIZE_BITS;
    localparam int unsigned ID_W   = `AXI_ID_BITS;
    localparam int unsigned IDS_W  = `AXI_IDS_BITS;
    localparam int unsigned DATA_W = `AXI_DATA_BITS;

    // One extra bit so ARLEN+1 never overflows.
    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Slave ID carries the master index just above the master's own ID bits so
    // the read data could be steered back even without the grant register.
    function automatic logic [IDS_W-1:0] make_ids(input logic g, input logic [ID_W-1:0] id);
        logic [IDS_W-1:0] v;
        v           = '0;
        v[ID_W-1:0] = id;
        v[ID_W]     = g;
        return v;
    endfunction

endpackage

// File: rtl/axi_rd_arb_grant.sv
// -----------------------------------------------------------------------------
// axi_rd_arb_grant
// Two-way request arbiter plus the registered grant for the current burst.
//
// Policy macro: AXI_RD_ARB_RR_EN
//   defined   : round-robin; on contention the master that did not win last
//               time is granted. A last-winner register (reset to M1) is kept.
//   undefined : fixed priority; M0 wins every contention. No last-winner state.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req0, req1 : ARVALID of master 0 / master 1
//   load       : arbitration point (FSM idle with a request pending)
//   winner     : combinational arbitration result for this cycle
//   grant      : registered master index owning the current burst
// -----------------------------------------------------------------------------
module axi_rd_arb_grant
    import axi_rd_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic load,
    output logic winner,
    output logic grant
);

    logic grant_q;

`ifdef AXI_RD_ARB_RR_EN
    logic last_q;

    always_comb begin
        if (req0 && req1) begin
            winner = ~last_q;
        end else if (req1) begin
            winner = M1;
        end else begin
            winner = M0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= M1;
        end else if (load) begin
            last_q <= winner;
        end
    end
`else
    always_comb begin
        if (req0) begin
            winner = M0;
        end else if (req1) begin
            winner = M1;
        end else begin
            winner = M0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= M0;
        end else if (load) begin
            grant_q <= winner;
        end
    end

    assign grant = grant_q;

endmodule

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Arbitrates the AXI read channels of two masters (M0, M1) onto one slave,
// with a single outstanding burst at a time.
//
// Policy macro: AXI_RD_ARB_RR_EN (round-robin when defined, M0 fixed priority
// otherwise); the choice lives in axi_rd_arb_grant.
//
// Ports:
//   ACLK, ARESETn               : clock, asynchronous active-low reset
//   AR*_M0 / AR*_M1             : master read-address channels
//   R*_M0  / R*_M1              : master read-data channels
//   AR*_S                       : slave read-address channel (ARID widened)
//   R*_S                        : slave read-data channel
//   rd_prot_err                 : one-cycle pulse, the cycle after an R
//                                 handshake whose RLAST disagrees with the
//                                 beat count implied by ARLEN
//
// Flow: idle -> (any ARVALID, latch grant, load counter) -> address phase
//       -> (AR handshake) -> data phase -> (R handshake with RLAST) -> idle.
// Everything not owned by the granted master in the current phase drives 0.
// -----------------------------------------------------------------------------
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESETn,
    // master 0 AR
    input  logic [ID_W-1:0]   ARID_M0,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [LEN_W-1:0]  ARLEN_M0,
    input  logic [SIZE_W-1:0] ARSIZE_M0,
    input  logic [1:0]        ARBURST_M0,
    input  logic              ARVALID_M0,
    output logic              ARREADY_M0,
    // master 1 AR
    input  logic [ID_W-1:0]   ARID_M1,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [LEN_W-1:0]  ARLEN_M1,
    input  logic [SIZE_W-1:0] ARSIZE_M1,
    input  logic [1:0]        ARBURST_M1,
    input  logic              ARVALID_M1,
    output logic              ARREADY_M1,
    // master 0 R
    output logic [ID_W-1:0]   RID_M0,
    output logic [DATA_W-1:0] RDATA_M0,
    output logic [1:0]        RRESP_M0,
    output logic              RLAST_M0,
    output logic              RVALID_M0,
    input  logic              RREADY_M0,
    // master 1 R
    output logic [ID_W-1:0]   RID_M1,
    output logic [DATA_W-1:0] RDATA_M1,
    output logic [1:0]        RRESP_M1,
    output logic              RLAST_M1,
    output logic              RVALID_M1,
    input  logic              RREADY_M1,
    // slave AR
    output logic [IDS_W-1:0]  ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [LEN_W-1:0]  ARLEN_S,
    output logic [SIZE_W-1:0] ARSIZE_S,
    output logic [1:0]        ARBURST_S,
    output logic              ARVALID_S,
    input  logic              ARREADY_S,
    // slave R
    input  logic [IDS_W-1:0]  RID_S,
    input  logic [DATA_W-1:0] RDATA_S,
    input  logic [1:0]        RRESP_S,
    input  logic              RLAST_S,
    input  logic              RVALID_S,
    output logic              RREADY_S,
    // status
    output logic              rd_prot_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             any_req;
    logic             load;
    logic             winner;
    logic             grant;
    logic             r_hs;
    logic [LEN_W-1:0] win_len;

    // Master index bits of RID_S are not needed: the grant register already
    // identifies the owner of the single outstanding burst.
    logic unused_rid_hi;
    assign unused_rid_hi = ^RID_S[IDS_W-1:ID_W];

    assign any_req = ARVALID_M0 || ARVALID_M1;
    assign load    = (state_q == StIdle) && any_req;
    assign r_hs    = (state_q == StData) && RVALID_S && RREADY_S;
    assign win_len = (winner == M1) ? ARLEN_M1 : ARLEN_M0;

    axi_rd_arb_grant u_grant (
        .clk    (ACLK),
        .rst_n  (ARESETn),
        .req0   (ARVALID_M0),
        .req1   (ARVALID_M1),
        .load   (load),
        .winner (winner),
        .grant  (grant)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (any_req) state_d = StAddr;
            // A master dropping ARVALID here is ignored: we stay until the
            // slave accepts the address.
            StAddr: if (ARREADY_S) state_d = StData;
            StData: if (r_hs && RLAST_S) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        ARID_S     = '0;
        ARADDR_S   = '0;
        ARLEN_S    = '0;
        ARSIZE_S   = '0;
        ARBURST_S  = '0;
        ARVALID_S  = 1'b0;
        RID_M0     = '0;
        RDATA_M0   = '0;
        RRESP_M0   = '0;
        RLAST_M0   = 1'b0;
        RVALID_M0  = 1'b0;
        RID_M1     = '0;
        RDATA_M1   = '0;
        RRESP_M1   = '0;
        RLAST_M1   = 1'b0;
        RVALID_M1  = 1'b0;
        RREADY_S   = 1'b0;
        unique case (state_q)
            StIdle: ;
            StAddr: begin
                ARVALID_S = 1'b1;
                if (grant == M1) begin
                    ARID_S     = make_ids(M1, ARID_M1);
                    ARADDR_S   = ARADDR_M1;
                    ARLEN_S    = ARLEN_M1;
                    ARSIZE_S   = ARSIZE_M1;
                    ARBURST_S  = ARBURST_M1;
                    ARREADY_M1 = ARREADY_S;
                end else begin
                    ARID_S     = make_ids(M0, ARID_M0);
                    ARADDR_S   = ARADDR_M0;
                    ARLEN_S    = ARLEN_M0;
                    ARSIZE_S   = ARSIZE_M0;
                    ARBURST_S  = ARBURST_M0;
                    ARREADY_M0 = ARREADY_S;
                end
            end
            StData: begin
                if (grant == M1) begin
                    RID_M1    = RID_S[ID_W-1:0];
                    RDATA_M1  = RDATA_S;
                    RRESP_M1  = RRESP_S;
                    RLAST_M1  = RLAST_S;
                    RVALID_M1 = RVALID_S;
                    RREADY_S  = RREADY_M1;
                end else begin
                    RID_M0    = RID_S[ID_W-1:0];
                    RDATA_M0  = RDATA_S;
                    RRESP_M0  = RRESP_S;
                    RLAST_M0  = RLAST_S;
                    RVALID_M0 = RVALID_S;
                    RREADY_S  = RREADY_M0;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------- beat counter
    // Holds the beats still expected; saturates at zero on overlong bursts.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(win_len) + CNT_W'(1);
        end else if (r_hs && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // RLAST early (count not yet at final beat) or missing on the final beat.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= r_hs && ((RLAST_S && (cnt_q != CNT_W'(1))) ||
                              (!RLAST_S && (cnt_q == CNT_W'(1))));
        end
    end

    assign rd_prot_err = err_q;

endmodule
